// File: rtl/htif_tohost.sv
// HTIF tohost/fromhost device: decodes core stores into exit pulses, console bytes
// and bad-command pulses, and answers reads of both mailbox words.
module htif_tohost #(
  parameter int                 ADDR_W        = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR   = 32'h8000_1000,
  parameter logic [ADDR_W-1:0]  FROMHOST_ADDR = 32'h8000_1040
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              tohost_we,
  output logic [31:0]       tohost,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic              bad_cmd
);

  localparam logic [15:0] PUTCHAR_TAG = 16'h0101;
  localparam logic [31:0] CON_ACK     = 32'h0101_0001;

  typedef enum logic [1:0] {IDLE, CONS, HALT} state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [31:0] tohost_q, tohost_q_d;
  logic [31:0] fromhost_q, fromhost_d;
  logic        resp_valid_d;
  logic [31:0] resp_rdata_d;
  logic        tohost_we_d;
  logic [31:0] tohost_d;
  logic        con_valid_d;
  logic [7:0]  con_data_d;
  logic        bad_cmd_d;
  logic        accept;
  logic        hit_to, hit_from;

  // run_q keeps req_ready low while reset is asserted, then opens on the first clock.
  assign req_ready = run_q && (state_q != CONS);
  assign accept    = req_valid && req_ready;
  assign hit_to    = (req_addr == TOHOST_ADDR);
  assign hit_from  = (req_addr == FROMHOST_ADDR);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      tohost_q   <= '0;
      fromhost_q <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      tohost_we  <= 1'b0;
      tohost     <= '0;
      con_valid  <= 1'b0;
      con_data   <= '0;
      bad_cmd    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      tohost_q   <= tohost_q_d;
      fromhost_q <= fromhost_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      tohost_we  <= tohost_we_d;
      tohost     <= tohost_d;
      con_valid  <= con_valid_d;
      con_data   <= con_data_d;
      bad_cmd    <= bad_cmd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tohost_q_d   = tohost_q;
    fromhost_d   = fromhost_q;
    resp_valid_d = accept;
    resp_rdata_d = '0;
    tohost_we_d  = 1'b0;
    tohost_d     = tohost;
    con_valid_d  = con_valid;
    con_data_d   = con_data;
    bad_cmd_d    = 1'b0;

    if (accept && !req_we) begin
      if (hit_to)        resp_rdata_d = tohost_q;
      else if (hit_from) resp_rdata_d = fromhost_q;
    end

    if (accept && req_we && hit_from) fromhost_d = req_wdata;

    // Putchar is tested before the exit bit: console bytes may legitimately be odd.
    if (accept && req_we && hit_to && state_q == IDLE) begin
      if (req_wdata == 32'h0) begin
        tohost_q_d = '0;
      end else if (req_wdata[31:16] == PUTCHAR_TAG) begin
        tohost_q_d  = req_wdata;
        con_valid_d = 1'b1;
        con_data_d  = req_wdata[7:0];
        state_d     = CONS;
      end else if (req_wdata[0]) begin
        tohost_q_d  = req_wdata;
        tohost_we_d = 1'b1;
        tohost_d    = req_wdata;
        state_d     = HALT;
      end else begin
        tohost_q_d = '0;
        bad_cmd_d  = 1'b1;
      end
    end

    if (state_q == CONS && con_valid && con_ready) begin
      con_valid_d = 1'b0;
      tohost_q_d  = '0;
      fromhost_d  = CON_ACK;
      state_d     = IDLE;
    end
  end

endmodule

// File: tb/tb_htif_tohost.sv
// Self-checking bench for htif_tohost: directed scenarios plus a randomized
// command stream checked against a mailbox-level reference model.
module tb_htif_tohost;

  localparam logic [31:0] TO_A   = 32'h8000_1000;
  localparam logic [31:0] FROM_A = 32'h8000_1040;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, tohost_we, con_valid, bad_cmd;
  logic [31:0] resp_rdata, tohost;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  logic        got_ready, got_resp, got_we, got_bad, got_cv;
  logic [31:0] got_rdata, got_tohost;
  logic [7:0]  got_cd;

  htif_tohost dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .tohost_we(tohost_we), .tohost(tohost),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .bad_cmd(bad_cmd)
  );

  always #5 CLK = ~CLK;

  // One bus transaction; captures what is visible one cycle after the accept edge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge CLK);
    got_ready = req_ready;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge CLK);
    got_resp = resp_valid; got_rdata = resp_rdata; got_we = tohost_we;
    got_bad = bad_cmd; got_cv = con_valid; got_cd = con_data; got_tohost = tohost;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    n_total++;
    if ({req_ready, resp_valid, resp_rdata, tohost_we, tohost, con_valid, con_data, bad_cmd} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got ready=%b resp=%b we=%b tohost=%h cv=%b bad=%b want all 0",
                        req_ready, resp_valid, tohost_we, tohost, con_valid, bad_cmd);
    end
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_map;
    bus(1'b0, 32'h8000_1004, '0);
    n_total++;
    if (got_resp !== 1'b1 || got_rdata !== 32'h0) begin
      n_bad++; $display("FAIL map_unmapped got resp=%b rdata=%h want resp=1 rdata=0", got_resp, got_rdata); end
    @(negedge CLK);
    n_total++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL map_resp_once got=%b want=0", resp_valid); end
    bus(1'b1, FROM_A, 32'h1234);
    n_total++;
    if (got_resp !== 1'b1 || got_rdata !== 32'h0) begin
      n_bad++; $display("FAIL map_write_resp got resp=%b rdata=%h want resp=1 rdata=0", got_resp, got_rdata); end
    bus(1'b0, FROM_A, '0);
    n_total++;
    if (got_rdata !== 32'h1234) begin n_bad++; $display("FAIL map_from_rd got=%h want=00001234", got_rdata); end
    bus(1'b0, 32'h0000_1040, '0);
    n_total++;
    if (got_rdata !== 32'h0) begin n_bad++; $display("FAIL map_alias got=%h want=0", got_rdata); end
    bus(1'b1, FROM_A, 32'h0);
    bus(1'b0, FROM_A, '0);
    n_total++;
    if (got_rdata !== 32'h0) begin n_bad++; $display("FAIL map_from_clr got=%h want=0", got_rdata); end
  endtask

  task automatic test_bad_cmd;
    bus(1'b1, TO_A, 32'h0200_0000);
    n_total++;
    if (got_resp !== 1'b1 || got_bad !== 1'b1 || got_we !== 1'b0 || got_cv !== 1'b0) begin
      n_bad++; $display("FAIL bad_pulse got resp=%b bad=%b we=%b cv=%b want 1 1 0 0", got_resp, got_bad, got_we, got_cv); end
    @(negedge CLK);
    n_total++;
    if (bad_cmd !== 1'b0) begin n_bad++; $display("FAIL bad_once got=%b want=0", bad_cmd); end
    bus(1'b0, TO_A, '0);
    n_total++;
    if (got_rdata !== 32'h0) begin n_bad++; $display("FAIL bad_tohost_rd got=%h want=0", got_rdata); end
  endtask

  task automatic test_putchar;
    con_ready = 1'b0;
    bus(1'b1, TO_A, 32'h0101_0041);
    n_total++;
    if (got_resp !== 1'b1 || got_cv !== 1'b1 || got_cd !== 8'h41 || got_we !== 1'b0) begin
      n_bad++; $display("FAIL put_start got resp=%b cv=%b cd=%h we=%b want 1 1 41 0", got_resp, got_cv, got_cd, got_we); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_total++;
      if (con_valid !== 1'b1 || con_data !== 8'h41 || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL put_hold%0d got cv=%b cd=%h ready=%b want 1 41 0", i, con_valid, con_data, req_ready); end
    end
    con_ready = 1'b1;
    @(negedge CLK);
    con_ready = 1'b0;
    n_total++;
    if (con_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL put_done got cv=%b ready=%b want 0 1", con_valid, req_ready); end
    bus(1'b0, FROM_A, '0);
    n_total++;
    if (got_rdata !== 32'h0101_0001) begin n_bad++; $display("FAIL put_ack got=%h want=01010001", got_rdata); end
    bus(1'b0, TO_A, '0);
    n_total++;
    if (got_rdata !== 32'h0) begin n_bad++; $display("FAIL put_tohost got=%h want=0", got_rdata); end
  endtask

  task automatic test_putchar_fast;
    con_ready = 1'b1;
    bus(1'b1, TO_A, 32'h0101_005A);
    n_total++;
    if (got_cv !== 1'b1 || got_cd !== 8'h5A) begin
      n_bad++; $display("FAIL fast_start got cv=%b cd=%h want 1 5a", got_cv, got_cd); end
    @(negedge CLK);
    n_total++;
    if (con_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL fast_one_cycle got cv=%b ready=%b want 0 1", con_valid, req_ready); end
    con_ready = 1'b0;
    bus(1'b1, FROM_A, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] th_m, fh_m, a, v, exp_rd;
    logic        exp_bad, exp_cv, is_rd;
    int          op, dly;
    th_m = '0; fh_m = '0;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      a = $urandom; v = $urandom;
      if (a == TO_A || a == FROM_A) a = a ^ 32'h4;
      exp_bad = 1'b0; exp_cv = 1'b0; exp_rd = '0; is_rd = 1'b0;
      case (op)
        0: begin a = TO_A;   is_rd = 1'b1; exp_rd = th_m; end
        1: begin a = FROM_A; is_rd = 1'b1; exp_rd = fh_m; end
        2: is_rd = 1'b1;
        3: begin a = FROM_A; fh_m = v; end
        4: begin
          a = TO_A;
          case ($urandom_range(0, 2))
            0: v = '0;
            1: v = {16'h0101, v[15:0]};
            default: begin
              v = v & ~32'h1;
              if (v == 0 || v[31:16] == 16'h0101) v = 32'h0200_0000;
            end
          endcase
          if (v[31:16] == 16'h0101) exp_cv = 1'b1;
          else if (v != 0) exp_bad = 1'b1;
          th_m = '0;
        end
        default: ;
      endcase
      bus(!is_rd, a, v);
      n_total++;
      if (got_ready !== 1'b1 || got_resp !== 1'b1 || got_rdata !== exp_rd || got_we !== 1'b0 ||
          got_bad !== exp_bad || got_cv !== exp_cv) begin
        n_bad++; $display("FAIL rand%0d op%0d got rdy=%b resp=%b rd=%h we=%b bad=%b cv=%b want 1 1 %h 0 %b %b",
                          n, op, got_ready, got_resp, got_rdata, got_we, got_bad, got_cv, exp_rd, exp_bad, exp_cv);
      end
      if (exp_cv) begin
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin
          @(negedge CLK);
          n_total++;
          if (con_valid !== 1'b1 || con_data !== v[7:0]) begin
            n_bad++; $display("FAIL rand%0d_hold got cv=%b cd=%h want 1 %h", n, con_valid, con_data, v[7:0]); end
        end
        con_ready = 1'b1;
        @(negedge CLK);
        con_ready = 1'b0;
        n_total++;
        if (con_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_done got cv=%b want 0", n, con_valid); end
        fh_m = 32'h0101_0001;
      end
    end
  endtask

  task automatic test_exit;
    bus(1'b1, TO_A, 32'h0000_0001);
    n_total++;
    if (got_resp !== 1'b1 || got_we !== 1'b1 || got_tohost !== 32'h1) begin
      n_bad++; $display("FAIL exit_pulse got resp=%b we=%b tohost=%h want 1 1 00000001", got_resp, got_we, got_tohost); end
    @(negedge CLK);
    n_total++;
    if (tohost_we !== 1'b0 || tohost !== 32'h1) begin
      n_bad++; $display("FAIL exit_once got we=%b tohost=%h want 0 00000001", tohost_we, tohost); end
    bus(1'b1, TO_A, 32'h0000_0003);
    n_total++;
    if (got_ready !== 1'b1 || got_resp !== 1'b1 || got_we !== 1'b0 || got_tohost !== 32'h1) begin
      n_bad++; $display("FAIL halt_rewrite got rdy=%b resp=%b we=%b tohost=%h want 1 1 0 00000001",
                        got_ready, got_resp, got_we, got_tohost); end
    bus(1'b1, TO_A, 32'h0101_0042);
    n_total++;
    if (got_cv !== 1'b0 || got_bad !== 1'b0) begin
      n_bad++; $display("FAIL halt_put got cv=%b bad=%b want 0 0", got_cv, got_bad); end
    bus(1'b0, TO_A, '0);
    n_total++;
    if (got_rdata !== 32'h1) begin n_bad++; $display("FAIL halt_tohost_rd got=%h want=00000001", got_rdata); end
    bus(1'b1, FROM_A, 32'h55);
    bus(1'b0, FROM_A, '0);
    n_total++;
    if (got_rdata !== 32'h55) begin n_bad++; $display("FAIL halt_from_rd got=%h want=00000055", got_rdata); end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK); RSTn = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++;
    if (tohost !== 32'h0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_unhalt got tohost=%h ready=%b want 0 1", tohost, req_ready); end
    con_ready = 1'b0;
    bus(1'b1, TO_A, 32'h0101_0033);
    n_total++;
    if (got_cv !== 1'b1) begin n_bad++; $display("FAIL rst_cons_start got cv=%b want 1", got_cv); end
    #2 RSTn = 1'b0;
    #1;
    n_total++;
    if ({req_ready, resp_valid, resp_rdata, tohost_we, tohost, con_valid, con_data, bad_cmd} !== '0) begin
      n_bad++; $display("FAIL rst_mid_clear got ready=%b cv=%b cd=%h we=%b bad=%b want all 0",
                        req_ready, con_valid, con_data, tohost_we, bad_cmd); end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++;
    if (req_ready !== 1'b1 || con_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_release got ready=%b cv=%b want 1 0", req_ready, con_valid); end
    bus(1'b1, TO_A, 32'h0000_0007);
    n_total++;
    if (got_we !== 1'b1 || got_tohost !== 32'h7) begin
      n_bad++; $display("FAIL rst_exit got we=%b tohost=%h want 1 00000007", got_we, got_tohost); end
  endtask

  initial begin
    test_reset;
    test_map;
    test_bad_cmd;
    test_putchar;
    test_putchar_fast;
    test_random;
    test_exit;
    test_reset_mid;
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
